// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA stream engine.
//   dma_state_e        : engine control states
//   MEM_READ_LATENCY   : fixed read-ack latency of the DMA memory port, in cycles
//   WORD_BYTES         : bytes per memory word
//   DEFAULT_FIFO_DEPTH : default return-FIFO depth
//   DEFAULT_LEN_W      : default width of the word-count field
//   word_addr()        : byte address of word idx relative to base, wrapping modulo 2^32
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  localparam int unsigned MEM_READ_LATENCY   = 11;
  localparam int unsigned WORD_BYTES         = 4;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;
  localparam int unsigned DEFAULT_LEN_W      = 16;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/dma_stream_engine_if.sv
// Signal bundle of the DMA stream engine: configuration/status, memory DMA port,
// stream-out (ss_*) and stream-in (sm_*) AXI-Stream channels.
//   modport master : the engine side
//   modport slave  : the environment side (host, memory, accelerator)
// err_tlast exists only when DMA_STREAM_TLAST_CHECK_EN is defined.
interface dma_stream_engine_if #(
  parameter int unsigned LEN_W = dma_pkg::DEFAULT_LEN_W
);
  logic             cfg_start;
  logic [31:0]      cfg_rd_base;
  logic [31:0]      cfg_wr_base;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             done;

  logic [31:0]      dma_addr;
  logic [31:0]      dma_data_o;
  logic             dma_we;
  logic             dma_en;
  logic [31:0]      dma_data_i;
  logic             dma_read_ack;

  logic [31:0]      ss_tdata;
  logic             ss_tvalid;
  logic             ss_tready;
  logic             ss_tlast;

  logic [31:0]      sm_tdata;
  logic             sm_tvalid;
  logic             sm_tready;
  logic             sm_tlast;

`ifdef DMA_STREAM_TLAST_CHECK_EN
  logic             err_tlast;

  modport master (
    input  cfg_start, cfg_rd_base, cfg_wr_base, cfg_len,
    output busy, done,
    output dma_addr, dma_data_o, dma_we, dma_en,
    input  dma_data_i, dma_read_ack,
    output ss_tdata, ss_tvalid, ss_tlast,
    input  ss_tready,
    input  sm_tdata, sm_tvalid, sm_tlast,
    output sm_tready,
    output err_tlast
  );

  modport slave (
    output cfg_start, cfg_rd_base, cfg_wr_base, cfg_len,
    input  busy, done,
    input  dma_addr, dma_data_o, dma_we, dma_en,
    output dma_data_i, dma_read_ack,
    input  ss_tdata, ss_tvalid, ss_tlast,
    output ss_tready,
    output sm_tdata, sm_tvalid, sm_tlast,
    input  sm_tready,
    input  err_tlast
  );
`else
  modport master (
    input  cfg_start, cfg_rd_base, cfg_wr_base, cfg_len,
    output busy, done,
    output dma_addr, dma_data_o, dma_we, dma_en,
    input  dma_data_i, dma_read_ack,
    output ss_tdata, ss_tvalid, ss_tlast,
    input  ss_tready,
    input  sm_tdata, sm_tvalid, sm_tlast,
    output sm_tready
  );

  modport slave (
    output cfg_start, cfg_rd_base, cfg_wr_base, cfg_len,
    input  busy, done,
    input  dma_addr, dma_data_o, dma_we, dma_en,
    output dma_data_i, dma_read_ack,
    input  ss_tdata, ss_tvalid, ss_tlast,
    output ss_tready,
    output sm_tdata, sm_tvalid, sm_tlast,
    input  sm_tready
  );
`endif

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output (no read latency).
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry (dropped when full unless popping in the same cycle)
//   pop      : remove the head entry (ignored when empty)
//   dout     : head entry, 0 while empty
//   count    : occupancy; empty/full flags
// DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dma_stream_engine.sv
// Memory-to-stream / stream-to-memory DMA engine.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dma_stream_engine_if.master
//              cfg_*   start pulse, read/write byte bases, word count per direction
//              busy/done status, dma_* single-port memory access (one per cycle),
//              ss_*    stream-out of words read from memory,
//              sm_*    stream-in of words written to memory.
// Reads are issued against a credit of FIFO_DEPTH return slots so the fixed
// memory read latency is absorbed by the return FIFO without overflow.
// Optional feature macro: DMA_STREAM_TLAST_CHECK_EN adds the sticky err_tlast
// flag that reports sm_tlast disagreeing with the expected final word.
module dma_stream_engine
  import dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned LEN_W      = DEFAULT_LEN_W
) (
  input logic                 clk,
  input logic                 rst,
  dma_stream_engine_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = LEN_W + 1;
  localparam logic [AW+1:0] DEPTH_LIM = (AW + 2)'(FIFO_DEPTH);

  dma_state_e       state_q, state_d;
  logic [31:0]      rd_base_q, wr_base_q;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    rd_issue_cnt_q, rd_issue_cnt_d;
  logic [CW-1:0]    rd_done_cnt_q, rd_done_cnt_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [AW:0]      outstanding_q, outstanding_d;
  logic             rr_q, rr_d;

  logic [CW-1:0]    len_ext, len_m1;
  logic [AW+1:0]    credit_used;
  logic             start;
  logic             rd_elig, wr_elig, rd_grant, wr_grant, wr_fire;

  logic [31:0]      fifo_dout;
  logic [AW:0]      fifo_count;
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop;

  assign len_ext = {1'b0, len_q};
  // For len == 0 this wraps to all ones, which no counter ever reaches.
  assign len_m1  = len_ext - CW'(1);
  assign start   = (state_q == IDLE) && bus.cfg_start;

  // ---------------------------------------------------------------------------
  // Arbitration: rr_q == 0 favours the read path when both are eligible.
  // The write grant never looks at sm_tvalid, so sm_tready is valid-independent.
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    rd_elig     = (state_q == RUN) && (rd_issue_cnt_q < len_ext) && (credit_used < DEPTH_LIM);
    wr_elig     = (state_q == RUN) && (wr_cnt_q < len_ext);
    rd_grant    = rd_elig && (!wr_elig || !rr_q);
    wr_grant    = wr_elig && (!rd_elig || rr_q);
    wr_fire     = wr_grant && bus.sm_tvalid;
    // Late acks from a transfer cut short by reset are dropped outside RUN.
    fifo_push   = bus.dma_read_ack && (state_q == RUN);
    fifo_pop    = !fifo_empty && bus.ss_tready;
  end

  // Counter next-state.
  always_comb begin
    rd_issue_cnt_d = rd_issue_cnt_q + CW'(rd_grant);
    rd_done_cnt_d  = rd_done_cnt_q + CW'(fifo_pop);
    wr_cnt_d       = wr_cnt_q + CW'(wr_fire);
    outstanding_d  = outstanding_q + (AW + 1)'(rd_grant) - (AW + 1)'(fifo_push);
    rr_d           = rr_q ^ (rd_grant || wr_fire);
    if (start) begin
      rd_issue_cnt_d = '0;
      rd_done_cnt_d  = '0;
      wr_cnt_d       = '0;
      outstanding_d  = '0;
      rr_d           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_base_q      <= '0;
      wr_base_q      <= '0;
      len_q          <= '0;
      rd_issue_cnt_q <= '0;
      rd_done_cnt_q  <= '0;
      wr_cnt_q       <= '0;
      outstanding_q  <= '0;
      rr_q           <= 1'b0;
    end else begin
      if (start) begin
        rd_base_q <= bus.cfg_rd_base;
        wr_base_q <= bus.cfg_wr_base;
        len_q     <= bus.cfg_len;
      end
      rd_issue_cnt_q <= rd_issue_cnt_d;
      rd_done_cnt_q  <= rd_done_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      outstanding_q  <= outstanding_d;
      rr_q           <= rr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Completion looks at next-cycle counts so done follows the final handshake
  // directly rather than one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cfg_start) state_d = RUN;
      RUN:     if ((rd_done_cnt_d == len_ext) && (wr_cnt_d == len_ext)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == RUN);
    bus.done       = (state_q == DONE);
    bus.dma_en     = rd_grant || wr_fire;
    bus.dma_we     = wr_fire;
    bus.dma_addr   = '0;
    bus.dma_data_o = '0;
    if (wr_fire) begin
      bus.dma_addr   = word_addr(wr_base_q, 32'(wr_cnt_q));
      bus.dma_data_o = bus.sm_tdata;
    end else if (rd_grant) begin
      bus.dma_addr   = word_addr(rd_base_q, 32'(rd_issue_cnt_q));
    end
    bus.ss_tvalid  = !fifo_empty;
    bus.ss_tdata   = fifo_dout;
    bus.ss_tlast   = (rd_done_cnt_q == len_m1) && !fifo_empty;
    bus.sm_tready  = wr_grant;
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.dma_data_i),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef DMA_STREAM_TLAST_CHECK_EN
  logic err_tlast_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      err_tlast_q <= 1'b0;
    end else if (wr_fire && (bus.sm_tlast != (wr_cnt_q == len_m1))) begin
      err_tlast_q <= 1'b1;
    end
  end

  assign bus.err_tlast = err_tlast_q;
`else
  logic unused_sm_tlast;
  assign unused_sm_tlast = bus.sm_tlast;
`endif

  // The credit rule must make a return into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

  // Full-rate reads need one slot per cycle of latency plus the FIFO write cycle.
  a_depth_ok: assert property (@(posedge clk)
    (FIFO_DEPTH >= MEM_READ_LATENCY + 1) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0));

endmodule

// File: tb/tb_dma_stream_engine.sv
`timescale 1ns/1ps
module tb_dma_stream_engine;
  import dma_pkg::*;

  localparam int unsigned LEN_W      = DEFAULT_LEN_W;
  localparam int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_stream_engine_if #(.LEN_W(LEN_W)) bus ();

  dma_stream_engine #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned salt;

  // Memory contents: explicit overrides, otherwise a salted hash of the address.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (mem_ovr.exists(addr)) return mem_ovr[addr];
    return (addr * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory read port: ack exactly MEM_READ_LATENCY cycles after the strobe cycle.
  logic [MEM_READ_LATENCY-1:0] ack_pipe = '0;
  logic [31:0]                 data_pipe [MEM_READ_LATENCY];

  always @(posedge clk) begin
    ack_pipe     <= {ack_pipe[MEM_READ_LATENCY-2:0], bus.dma_en && !bus.dma_we};
    data_pipe[0] <= mem_word(bus.dma_addr);
    for (int i = 1; i < MEM_READ_LATENCY; i++) data_pipe[i] <= data_pipe[i-1];
  end

  assign bus.dma_read_ack = ack_pipe[MEM_READ_LATENCY-1];
  assign bus.dma_data_i   = data_pipe[MEM_READ_LATENCY-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idle_flags();
    logic [31:0] f;
    f = {21'd0, bus.busy, bus.done, bus.dma_en, bus.dma_we, bus.ss_tvalid, bus.ss_tlast,
         bus.sm_tready, |bus.dma_addr, |bus.dma_data_o, |bus.ss_tdata, 1'b0};
`ifdef DMA_STREAM_TLAST_CHECK_EN
    f[0] = bus.err_tlast;
`endif
    return f;
  endfunction

  // Results of the most recent transfer.
  int          r_first_rd, r_first_valid, r_acc_n;
  logic [63:0] r_acc_pat;

  // Runs one transfer; cycle 0 is the start cycle. Expectations come from the
  // transfer rules: word i read from rb+4i, streamed in order, written to wb+4i.
  task automatic run_xfer(input string name, input logic [31:0] rb, input logic [31:0] wb,
                          input int len, input int rdy_pct, input int vld_pct,
                          input int stall_lo, input int stall_hi, input int tlast_at,
                          input bit seq_data);
    logic [31:0] sm_words [$];
    int got, sent, issued, last_ss, last_wr, done_c, max_infl, err_c, bad_hs_c, fin;
    got = 0; sent = 0; issued = 0; last_ss = 0; last_wr = 0; done_c = -1; max_infl = 0;
    err_c = -1; bad_hs_c = -1;
    r_first_rd = -1; r_first_valid = -1; r_acc_n = 0; r_acc_pat = '0;
    for (int i = 0; i < len; i++) sm_words.push_back(seq_data ? 32'(i + 1) : $urandom);

    @(negedge clk);
    bus.cfg_rd_base = rb;
    bus.cfg_wr_base = wb;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_start   = 1'b1;
    bus.ss_tready   = 1'b0;
    bus.sm_tvalid   = 1'b0;
    @(negedge clk);
    bus.cfg_start   = 1'b0;

    for (int c = 1; c <= 3000 && done_c < 0; c++) begin
      bus.ss_tready = !(c >= stall_lo && c <= stall_hi) && ($urandom_range(99) < rdy_pct);
      bus.sm_tvalid = (sent < len) && ($urandom_range(99) < vld_pct);
      bus.sm_tdata  = (sent < len) ? sm_words[sent] : 32'd0;
      bus.sm_tlast  = (tlast_at < 0) ? (sent == len - 1) : (sent == tlast_at);
      #1;
      if (c == 1) check({name, " busy_rise"}, 32'(bus.busy), 32'd1);
`ifdef DMA_STREAM_TLAST_CHECK_EN
      if (err_c < 0 && bus.err_tlast) err_c = c;
`endif
      if (bus.done) begin
        done_c = c;
        check({name, " busy_fall"}, 32'(bus.busy), 32'd0);
      end else begin
        if (issued - got > max_infl) max_infl = issued - got;
        if (bus.ss_tvalid && r_first_valid < 0) r_first_valid = c;
        if (bus.ss_tvalid && bus.ss_tready) begin
          check({name, " ss_tdata"}, bus.ss_tdata, mem_word(rb + 32'(got) * 32'd4));
          check({name, " ss_tlast"}, 32'(bus.ss_tlast), 32'(got == len - 1));
          got++;
          last_ss = c;
        end
        if (bus.dma_en) begin
          if (r_acc_n < 64) r_acc_pat[r_acc_n] = bus.dma_we;
          r_acc_n++;
        end
        if (bus.dma_en && !bus.dma_we) begin
          check({name, " rd_addr"}, bus.dma_addr, rb + 32'(issued) * 32'd4);
          if (issued == 0) r_first_rd = c;
          issued++;
        end
        if (bus.dma_en && bus.dma_we) begin
          check({name, " wr_hs"}, 32'(bus.sm_tvalid && bus.sm_tready), 32'd1);
          check({name, " wr_addr"}, bus.dma_addr, wb + 32'(sent) * 32'd4);
          check({name, " wr_data"}, bus.dma_data_o, sm_words[sent]);
          if (bad_hs_c < 0 && (bus.sm_tlast != (sent == len - 1))) bad_hs_c = c;
          sent++;
          last_wr = c;
        end
      end
      @(negedge clk);
    end

    check({name, " done_seen"}, 32'(done_c > 0), 32'd1);
    fin = (last_ss > last_wr) ? last_ss : last_wr;
    if (len == 0) begin
      check({name, " done_cycle"}, 32'(done_c), 32'd2);
      check({name, " no_access"}, 32'(r_acc_n), 32'd0);
    end else begin
      check({name, " done_cycle"}, 32'(done_c), 32'(fin + 1));
      check({name, " first_rd"}, 32'(r_first_rd), 32'd1);
    end
    check({name, " words_out"}, 32'(got), 32'(len));
    check({name, " words_in"}, 32'(sent), 32'(len));
    check({name, " reads"}, 32'(issued), 32'(len));
    check({name, " credit"}, 32'(max_infl <= int'(FIFO_DEPTH)), 32'd1);
`ifdef DMA_STREAM_TLAST_CHECK_EN
    if (tlast_at >= 0) begin
      check({name, " err_rise"}, 32'(err_c), 32'(bad_hs_c + 1));
      check({name, " err_held"}, 32'(bus.err_tlast), 32'd1);
    end else begin
      check({name, " err_clear"}, 32'(err_c), 32'hFFFF_FFFF);
    end
`endif
    #1;
    check({name, " done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    bus.ss_tready = 1'b0;
    bus.sm_tvalid = 1'b0;
  endtask

  initial begin
    int n, bad;
    salt            = $urandom;
    bus.cfg_start   = 1'b0;
    bus.cfg_rd_base = '0;
    bus.cfg_wr_base = '0;
    bus.cfg_len     = '0;
    bus.ss_tready   = 1'b0;
    bus.sm_tdata    = '0;
    bus.sm_tvalid   = 1'b0;
    bus.sm_tlast    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_values", idle_flags(), 32'd0);
    rst = 1'b0;

    // Memory to stream with A0..A3; first word 12 cycles after its strobe.
    for (int i = 0; i < 4; i++) mem_ovr[32'h100 + 32'(i) * 32'd4] = 32'hA0 + 32'(i);
    run_xfer("m2s", 32'h100, 32'h4000, 4, 100, 100, 1, 0, -1, 1'b0);
    check("m2s latency", 32'(r_first_valid - r_first_rd), 32'(MEM_READ_LATENCY + 1));

    // Stream to memory with words 1,2,3.
    run_xfer("s2m", 32'h5000, 32'h200, 3, 100, 100, 1, 0, -1, 1'b1);

    // Concurrent: accesses alternate R,W,... starting with the read.
    run_xfer("conc", 32'h6000, 32'h7000, 8, 100, 100, 1, 0, -1, 1'b0);
    check("conc acc_count", 32'(r_acc_n), 32'd16);
    check("conc acc_pattern", r_acc_pat[31:0], 32'h0000_AAAA);

    // Backpressure on the stream-out side.
    run_xfer("bp", 32'h8000, 32'h9000, 32, 100, 100, 5, 40, -1, 1'b0);

    // Zero length.
    run_xfer("zero", 32'h0, 32'h0, 0, 100, 100, 1, 0, -1, 1'b0);

    // Randomized transfers.
    for (int k = 0; k < 3; k++) begin
      run_xfer("rand", {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               int'($urandom_range(40, 1)), 70, 60, int'($urandom_range(30, 1)),
               int'($urandom_range(60, 20)), -1, 1'b0);
    end

`ifdef DMA_STREAM_TLAST_CHECK_EN
    run_xfer("tlast_bad", 32'hA000, 32'hB000, 4, 100, 100, 1, 0, 2, 1'b0);
    run_xfer("tlast_clr", 32'h0, 32'h0, 0, 100, 100, 1, 0, -1, 1'b0);
`endif

    // Reset mid-transfer after 5 reads; late acks must not surface.
    @(negedge clk);
    bus.cfg_rd_base = 32'hC000;
    bus.cfg_wr_base = 32'hD000;
    bus.cfg_len     = LEN_W'(32);
    bus.cfg_start   = 1'b1;
    @(negedge clk);
    bus.cfg_start   = 1'b0;
    bus.ss_tready   = 1'b1;
    bus.sm_tvalid   = 1'b1;
    bus.sm_tdata    = 32'h1234_5678;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      #1;
      if (bus.dma_en && !bus.dma_we) n++;
      @(negedge clk);
    end
    check("rst reads_before", 32'(n), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst outputs", idle_flags(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.ss_tvalid || bus.dma_en || bus.busy) bad++;
      @(negedge clk);
    end
    check("rst late_acks", 32'(bad), 32'd0);
    bus.sm_tvalid = 1'b0;
    bus.ss_tready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_stream_engine.md
# dma_stream_engine

Memory-to-stream / stream-to-memory DMA engine that drives the DMA port of the user-project DMA memory. It reads a block of words from memory and streams it out to the accelerator on an AXI-Stream master, while writing the accelerator's result stream back to memory. It issues at most one memory access per cycle and absorbs the memory's fixed 11-cycle read latency with an internal return FIFO.

## Interface
- FIFO_DEPTH, 16, return-FIFO entries; power of two, ≥ 12 so the read path can run at full rate.
- LEN_W, 16, width of the word-count field.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle start pulse; ignored while busy.
- cfg_rd_base  in  32  byte address of the first word to read; must be word aligned.
- cfg_wr_base  in  32  byte address of the first word to write; must be word aligned.
- cfg_len  in  LEN_W  words per direction; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- dma_addr  out  32  memory byte address.
- dma_data_o  out  32  memory write data.
- dma_we  out  1  1 = write, 0 = read.
- dma_en  out  1  one-cycle access strobe; each high cycle is one access.
- dma_data_i  in  32  memory read data, valid while dma_read_ack is high.
- dma_read_ack  in  1  read return, exactly 11 cycles after the read strobe.
- ss_tdata  out  32  stream-out data.
- ss_tvalid  out  1  stream-out valid.
- ss_tready  in  1  stream-out ready.
- ss_tlast  out  1  high on the final stream-out word.
- sm_tdata  in  32  stream-in data.
- sm_tvalid  in  1  stream-in valid.
- sm_tready  out  1  stream-in ready.
- sm_tlast  in  1  stream-in last marker.
- err_tlast  out  1  present only with the configuration macro defined; see Configuration.

## Operation
- **States**
  - IDLE → RUN on cfg_start; the start cycle latches the bases and length, and clears all counters.
  - RUN → DONE when rd_done_cnt == len and wr_cnt == len.
  - DONE → IDLE after one cycle; done is high only while in DONE.
  - If cfg_len == 0: IDLE → RUN → DONE with no memory or stream activity, so done arrives 2 cycles after start.
- **Read issue** (rd_req): allowed when rd_issue_cnt < len and outstanding + fifo_count < FIFO_DEPTH.
  - Drives dma_en=1, dma_we=0, dma_addr = rd_base + 4·rd_issue_cnt.
  - Increments rd_issue_cnt and outstanding.
- **Read return**: dma_read_ack pushes dma_data_i into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO never overflows.
  - A return that would overflow is an assertion failure.
- **Stream out**
  - ss_tvalid = FIFO not empty; ss_tdata = FIFO head.
  - A handshake (ss_tvalid & ss_tready) pops the FIFO and increments rd_done_cnt.
  - ss_tlast = (rd_done_cnt == len−1) & ss_tvalid.
- **Write path**
  - sm_tready = RUN & wr_cnt < len & write slot granted this cycle.
  - A handshake drives dma_en=1, dma_we=1, dma_data_o = sm_tdata, dma_addr = wr_base + 4·wr_cnt, and increments wr_cnt.
  - Writes need no acknowledgement.
- **Arbitration**
  - When a read and a write are both eligible, a round-robin bit alternates the grant and flips on every granted access.
  - A lone requester always wins.
  - sm_tready is computed from eligibility and the grant only, never from sm_tvalid.
- **Arithmetic**: addresses wrap modulo 2^32; counters are LEN_W+1 bits wide; outstanding and fifo_count are log2(FIFO_DEPTH)+1 bits wide.

## Timing
- **Reset values**: state IDLE; busy, done, dma_en, dma_we, ss_tvalid, ss_tlast, sm_tready and err_tlast all 0; dma_addr, dma_data_o and ss_tdata 0; FIFO empty; counters 0.
- **Start**: busy rises the cycle after cfg_start; the first read strobe is issued in that same cycle.
- **Read latency**: the first word reaches ss_tvalid 12 cycles after its strobe: 11 cycles of memory latency plus 1 FIFO write cycle.
- **Throughput**: with ss_tready held high and no writes, one read is issued and one word is streamed per cycle.
- **Done**: done asserts the cycle after the last stream-out handshake or the last write, whichever is later. busy falls in that same cycle.
- **Reset mid-transfer**: returns to the reset values on the next edge. Read acks that arrive after the reset are discarded; pushes are enabled only in RUN.
- **Simultaneous push and pop**: fifo_count is unchanged.
- **cfg_start while busy**: ignored.

## Configuration
- DMA_STREAM_TLAST_CHECK_EN
- **Defined**
  - The err_tlast port exists.
  - It sets sticky (cleared on start or reset) when a stream-in handshake has sm_tlast != (wr_cnt == len−1).
  - Transfer behaviour is otherwise unchanged.
- **Undefined**: sm_tlast is ignored, and the err_tlast port and its logic are absent.

## Structure
- **Package dma_pkg**
  - State enum {IDLE, RUN, DONE}.
  - MEM_READ_LATENCY = 11, WORD_BYTES = 4.
  - Default FIFO_DEPTH and LEN_W.
- **Sub-module sync_fifo**
  - Parameterised width and depth; push, pop, dout, count, empty, full.
  - Single clock, synchronous active-high reset.
  - Output is the head entry; no read latency.

## Test plan
- **Memory to stream**: rd_base=0x100, len=4, ss_tready=1, memory words 0xA0..0xA3 → ss_tdata A0,A1,A2,A3 on consecutive cycles, ss_tlast on A3; first word 12 cycles after the first strobe; done once.
- **Backpressure**: len=32, ss_tready low for cycles 5..40 → outstanding+fifo_count never exceeds 16, no word lost or reordered, all 32 words delivered.
- **Stream to memory**: wr_base=0x200, len=3, sm words 1,2,3 → writes to 0x200, 0x204, 0x208; dma_we=1; done after the third write.
- **Concurrent read and write**: len=8 each, both streams always ready/valid → accesses alternate R,W,R,W…; both directions complete; done one cycle after the later finish.
- **Zero length and reset**: cfg_len=0 → done 2 cycles after start, dma_en never high. Reset asserted mid-transfer after 5 reads → all outputs return to reset values and late acks produce no ss_tvalid.
- **Tlast check** (macro defined): len=4 with sm_tlast on word 2 → err_tlast=1 from the next cycle and held until the next start.
